mem_port_arbiter: RTL and testbench

- Shares the single backing data_memory port between three requesters: the instruction-cache refill path, the data-cache miss/writeback path, and the store-buffer drain.
- Sits between the cache/store-buffer memory-side interfaces and data_memory.
- Replaces the hard-wired always-ready memory with a sequenced, fixed-latency access engine, one transaction at a time.
- Chooses a winner by priority with a store-buffer starvation guard, latches the request, waits MEM_LATENCY cycles, performs the access, then pulses the winner's ready.

---
 rtl/mem_port_arbiter.sv | 243 ++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 504 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single data_memory port between the data-cache path (D),
//   the instruction refill path (I) and the store-buffer drain (SB).
//   One transaction at a time: arbitrate in IDLE, latch the winner's
//   request, wait MEM_LATENCY cycles, then perform the access for exactly
//   one cycle while pulsing the winner's ready.
//
//   Handshake: a requester raises *_req with its fields and holds them
//   until its *_ready pulse; requests are sampled only while IDLE, the
//   fields are latched on the accept edge, and *_ready is a single-cycle
//   pulse in ACCESS (read data valid only during that pulse). A request
//   dropped after accept still completes and still pulses ready.
//
//   Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration
//   (D -> I -> SB, starting after the last winner). Without it, fixed
//   priority D > I > SB with a store-buffer starvation guard.
//
//   Ports
//     clk, reset                 clock, synchronous active-high reset
//     d_req/d_we/d_addr/d_wdata/d_be, d_ready/d_rdata   data-cache side
//     i_req/i_addr, i_ready/i_rdata                     refill side (read)
//     sb_req/sb_addr/sb_data/sb_be, sb_ready            store buffer (write)
//     mem_read_en/mem_write_en/mem_addr/mem_wdata/mem_byte_en, mem_rdata
//                                                       data_memory side
//     busy                       high in WAIT or ACCESS
//     grant                      current owner 0=D 1=I 2=SB 3=none
//     dbg_state                  FSM state (0 IDLE, 1 WAIT, 2 ACCESS)
module mem_port_arbiter #(
  parameter int MEM_LATENCY  = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        sb_req,
  input  logic [31:0] sb_addr,
  input  logic [31:0] sb_data,
  input  logic [3:0]  sb_be,
  output logic        sb_ready,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_en,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic [1:0]  grant,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  localparam logic [1:0] OWN_D    = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_SB   = 2'd2;
  localparam logic [1:0] OWN_NONE = 2'd3;

  // The accept edge itself counts as the first latency cycle and the
  // WAIT->ACCESS step as the last, hence the "- 2".
  localparam logic [3:0] WAIT_INIT = (MEM_LATENCY >= 2) ? 4'(MEM_LATENCY - 2) : 4'd0;

  state_t      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [1:0]  owner_q, owner_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  winner;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // rr_q holds the requester the next search starts from.
  logic [1:0] rr_q, rr_d;

  always_comb begin
    winner = OWN_NONE;
    case (rr_q)
      OWN_I:   winner = i_req  ? OWN_I  : sb_req ? OWN_SB : d_req  ? OWN_D : OWN_NONE;
      OWN_SB:  winner = sb_req ? OWN_SB : d_req  ? OWN_D  : i_req  ? OWN_I : OWN_NONE;
      default: winner = d_req  ? OWN_D  : i_req  ? OWN_I  : sb_req ? OWN_SB : OWN_NONE;
    endcase
  end

  always_comb begin
    rr_d = rr_q;
    if (state_q == S_IDLE && winner != OWN_NONE) begin
      rr_d = (winner == OWN_SB) ? OWN_D : winner + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rr_q <= OWN_D;
    else       rr_q <= rr_d;
  end
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);
  logic [3:0] starve_q, starve_d;

  always_comb begin
    winner = OWN_NONE;
    if (sb_req && starve_q >= STARVE_LIM) winner = OWN_SB;
    else if (d_req)                       winner = OWN_D;
    else if (i_req)                       winner = OWN_I;
    else if (sb_req)                      winner = OWN_SB;
  end

  // Counts consecutive IDLE accepts that SB lost while requesting; any
  // IDLE cycle without sb_req, or an SB grant, restarts the count.
  always_comb begin
    starve_d = starve_q;
    if (state_q == S_IDLE) begin
      if (!sb_req || winner == OWN_SB) starve_d = 4'd0;
      else if (starve_q != 4'hF)       starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) starve_q <= 4'd0;
    else       starve_q <= starve_d;
  end
`endif

  // Next-state and request latch.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    case (state_q)
      S_IDLE: begin
        if (winner != OWN_NONE) begin
          owner_d = winner;
          case (winner)
            OWN_D: begin
              we_d    = d_we;
              addr_d  = d_addr;
              wdata_d = d_we ? d_wdata : 32'd0;
              be_d    = d_we ? d_be : 4'd0;
            end
            OWN_I: begin
              we_d    = 1'b0;
              addr_d  = i_addr;
              wdata_d = 32'd0;
              be_d    = 4'd0;
            end
            default: begin
              we_d    = 1'b1;
              addr_d  = sb_addr;
              wdata_d = sb_data;
              be_d    = sb_be;
            end
          endcase
          if (MEM_LATENCY == 1) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_WAIT;
            wait_d  = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (wait_q == 4'd0) state_d = S_ACCESS;
        else                wait_d  = wait_q - 4'd1;
      end
      S_ACCESS: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      wait_q  <= 4'd0;
      owner_q <= OWN_NONE;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  // Memory port and completion outputs are only non-zero in ACCESS.
  always_comb begin
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    mem_addr     = 32'd0;
    mem_wdata    = 32'd0;
    mem_byte_en  = 4'd0;
    d_ready      = 1'b0;
    i_ready      = 1'b0;
    sb_ready     = 1'b0;
    d_rdata      = 32'd0;
    i_rdata      = 32'd0;
    if (state_q == S_ACCESS) begin
      mem_read_en  = ~we_q;
      mem_write_en = we_q;
      mem_addr     = addr_q;
      mem_wdata    = wdata_q;
      mem_byte_en  = be_q;
      d_ready      = (owner_q == OWN_D);
      i_ready      = (owner_q == OWN_I);
      sb_ready     = (owner_q == OWN_SB);
      if (!we_q && owner_q == OWN_D) d_rdata = mem_rdata;
      if (!we_q && owner_q == OWN_I) i_rdata = mem_rdata;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign grant     = (state_q == S_IDLE) ? OWN_NONE : owner_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Bench for mem_port_arbiter. The main instance runs with MEM_LATENCY=4,
//   STARVE_LIMIT=8 against a word-addressed memory array; a second instance
//   with MEM_LATENCY=1 shares the requester inputs and reads the same array.
//   Window k of a transaction is the clock period following the k-th edge
//   after the accept edge (window 0 follows the accept edge itself).
module tb_mem_port_arbiter;

  localparam int LAT   = 4;
  localparam int LIMIT = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // ---------------- DUT signals ----------------
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        sb_req = 1'b0;
  logic [31:0] sb_addr = '0, sb_data = '0;
  logic [3:0]  sb_be = '0;

  logic        d_ready, i_ready, sb_ready;
  logic [31:0] d_rdata, i_rdata;
  logic        mem_read_en, mem_write_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_byte_en;
  logic        busy;
  logic [1:0]  grant, dbg_state;

  logic        d_ready1, i_ready1, sb_ready1;
  logic [31:0] d_rdata1, i_rdata1;
  logic        mem_read_en1, mem_write_en1;
  logic [31:0] mem_addr1, mem_wdata1, mem_rdata1;
  logic [3:0]  mem_byte_en1;
  logic        busy1;
  logic [1:0]  grant1, dbg_state1;

  // ---------------- backing memory ----------------
  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];

  assign mem_rdata  = mem[mem_addr[9:2]];
  assign mem_rdata1 = mem[mem_addr1[9:2]];

  always @(posedge clk) begin
    if (mem_write_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_byte_en[b]) mem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
    end
  end

  mem_port_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(LIMIT)) u_dut (
    .clk(clk), .reset(reset),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .sb_req(sb_req), .sb_addr(sb_addr), .sb_data(sb_data), .sb_be(sb_be),
    .sb_ready(sb_ready),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en), .mem_rdata(mem_rdata),
    .busy(busy), .grant(grant), .dbg_state(dbg_state)
  );

  mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(LIMIT)) u_dut1 (
    .clk(clk), .reset(reset),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ready(d_ready1), .d_rdata(d_rdata1),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready1), .i_rdata(i_rdata1),
    .sb_req(sb_req), .sb_addr(sb_addr), .sb_data(sb_data), .sb_be(sb_be),
    .sb_ready(sb_ready1),
    .mem_read_en(mem_read_en1), .mem_write_en(mem_write_en1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_byte_en(mem_byte_en1), .mem_rdata(mem_rdata1),
    .busy(busy1), .grant(grant1), .dbg_state(dbg_state1)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    i_req = 1'b0; i_addr = '0;
    sb_req = 1'b0; sb_addr = '0; sb_data = '0; sb_be = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(0, 255)) << 2;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [136:0] got;
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    got = {mem_read_en, mem_write_en, mem_addr, mem_wdata, mem_byte_en,
           d_ready, i_ready, sb_ready, d_rdata, i_rdata};
    tests_run++;
    if (got !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h expected 0", got);
    end
    tests_run++;
    if ({busy, grant} !== 3'b011) begin
      tests_failed++;
      $display("FAIL reset_grant: got busy=%b grant=%0d expected busy=0 grant=3", busy, grant);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    mem[64] = 32'hDEADBEEF;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_wdata = $urandom; d_be = 4'hF;
    for (int k = 0; k <= LAT; k++) begin
      @(negedge clk);
      if (k == 0) begin
        tests_run++;
        if (grant !== 2'd0) begin
          tests_failed++;
          $display("FAIL single_grant: got %0d expected 0", grant);
        end
      end
      if (k == LAT - 1) begin
        tests_run++;
        if ({mem_read_en, mem_write_en, mem_addr, d_ready, d_rdata} !==
            {1'b1, 1'b0, 32'h100, 1'b1, 32'hDEADBEEF}) begin
          tests_failed++;
          $display("FAIL single_access: got rd=%b wr=%b addr=%h rdy=%b data=%h expected rd=1 wr=0 addr=100 rdy=1 data=deadbeef",
                   mem_read_en, mem_write_en, mem_addr, d_ready, d_rdata);
        end
        d_req = 1'b0;
      end else begin
        tests_run++;
        if ({mem_read_en, d_ready, d_rdata} !== '0) begin
          tests_failed++;
          $display("FAIL single_quiet_w%0d: got rd=%b rdy=%b data=%h expected 0", k, mem_read_en, d_ready, d_rdata);
        end
      end
      if (k == LAT) begin
        tests_run++;
        if (grant !== 2'd3) begin
          tests_failed++;
          $display("FAIL single_release: got grant %0d expected 3", grant);
        end
      end
    end
  endtask

  task automatic test_dual_read();
    do_reset();
    mem[64] = 32'hDEADBEEF;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_be = 4'hF;
    i_req = 1'b1; i_addr = 32'h100;
    for (int k = 0; k <= 2 * LAT + 1; k++) begin
      @(negedge clk);
      if (k == 0 || k == LAT + 1) begin
        tests_run++;
        if (grant !== ((k == 0) ? 2'd0 : 2'd1)) begin
          tests_failed++;
          $display("FAIL dual_grant_w%0d: got %0d expected %0d", k, grant, (k == 0) ? 0 : 1);
        end
      end
      if (k == LAT - 1) begin
        tests_run++;
        if ({d_ready, i_ready, d_rdata} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
          tests_failed++;
          $display("FAIL dual_d_done: got d_rdy=%b i_rdy=%b data=%h expected 1 0 deadbeef", d_ready, i_ready, d_rdata);
        end
        d_req = 1'b0;
      end else if (k == 2 * LAT) begin
        tests_run++;
        if ({d_ready, i_ready, i_rdata} !== {1'b0, 1'b1, 32'hDEADBEEF}) begin
          tests_failed++;
          $display("FAIL dual_i_done: got d_rdy=%b i_rdy=%b data=%h expected 0 1 deadbeef", d_ready, i_ready, i_rdata);
        end
        i_req = 1'b0;
      end else begin
        tests_run++;
        if ({d_ready, i_ready} !== 2'b00) begin
          tests_failed++;
          $display("FAIL dual_quiet_w%0d: got d_rdy=%b i_rdy=%b expected 0 0", k, d_ready, i_ready);
        end
      end
    end
  endtask

  task automatic test_latency_one();
    do_reset();
    mem[32] = 32'hCAFEF00D;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_be = 4'hF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests_run++;
      if (k == 1) begin
        if ({grant1, d_ready1, mem_read_en1} !== {2'd3, 1'b0, 1'b0}) begin
          tests_failed++;
          $display("FAIL lat1_gap: got grant=%0d rdy=%b rd=%b expected 3 0 0", grant1, d_ready1, mem_read_en1);
        end
      end else begin
        if ({grant1, d_ready1, mem_read_en1, d_rdata1} !== {2'd0, 1'b1, 1'b1, 32'hCAFEF00D}) begin
          tests_failed++;
          $display("FAIL lat1_access_w%0d: got grant=%0d rdy=%b rd=%b data=%h expected 0 1 1 cafef00d",
                   k, grant1, d_ready1, mem_read_en1, d_rdata1);
        end
      end
    end
    d_req = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    mem[80] = 32'h11111111;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h140; d_wdata = 32'hFFFFFFFF; d_be = 4'hF;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      tests_run++;
      if ({busy, mem_write_en} !== 2'b10) begin
        tests_failed++;
        $display("FAIL midrst_wait_w%0d: got busy=%b wr=%b expected 1 0", k, busy, mem_write_en);
      end
    end
    reset = 1'b1;
    d_req = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({busy, grant, mem_write_en, d_ready} !== 5'b01100) begin
      tests_failed++;
      $display("FAIL midrst_abort: got busy=%b grant=%0d wr=%b rdy=%b expected 0 3 0 0", busy, grant, mem_write_en, d_ready);
    end
    reset = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      tests_run++;
      if ({mem_write_en, d_ready} !== 2'b00) begin
        tests_failed++;
        $display("FAIL midrst_quiet_w%0d: got wr=%b rdy=%b expected 0 0", k, mem_write_en, d_ready);
      end
    end
    tests_run++;
    if (mem[80] !== 32'h11111111) begin
      tests_failed++;
      $display("FAIL midrst_mem: got %h expected 11111111", mem[80]);
    end
  endtask

`ifndef MEM_ARB_ROUND_ROBIN_EN
  task automatic test_starvation();
    logic [1:0] wins[$];
    logic [1:0] prev_g;
    bit sb_seen;
    do_reset();
    mem[16] = 32'h12345600;
    sb_req = 1'b1; sb_addr = 32'h40; sb_data = 32'h000000AA; sb_be = 4'b0001;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_be = 4'hF;
    prev_g = 2'd3;
    sb_seen = 1'b0;
    for (int k = 0; k < 12 * (LAT + 1); k++) begin
      @(negedge clk);
      if (grant != 2'd3 && prev_g == 2'd3) wins.push_back(grant);
      prev_g = grant;
      if (mem_write_en) begin
        sb_seen = 1'b1;
        tests_run++;
        if ({mem_addr, mem_wdata, mem_byte_en, sb_ready} !== {32'h40, 32'hAA, 4'b0001, 1'b1}) begin
          tests_failed++;
          $display("FAIL starve_write: got addr=%h data=%h be=%b rdy=%b expected 40 aa 0001 1",
                   mem_addr, mem_wdata, mem_byte_en, sb_ready);
        end
        break;
      end
    end
    sb_req = 1'b0;
    d_req = 1'b0;
    tests_run++;
    if (!sb_seen || wins.size() != LIMIT + 1) begin
      tests_failed++;
      $display("FAIL starve_count: got sb_write=%b arbitrations=%0d expected 1 %0d", sb_seen, wins.size(), LIMIT + 1);
    end
    for (int i = 0; i < wins.size(); i++) begin
      tests_run++;
      if (wins[i] !== ((i < LIMIT) ? 2'd0 : 2'd2)) begin
        tests_failed++;
        $display("FAIL starve_win%0d: got %0d expected %0d", i, wins[i], (i < LIMIT) ? 0 : 2);
      end
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if (mem[16] !== 32'h123456AA) begin
      tests_failed++;
      $display("FAIL starve_mem: got %h expected 123456aa", mem[16]);
    end
  endtask
`else
  task automatic test_round_robin();
    logic [1:0] wins[$];
    logic [1:0] prev_g;
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    i_req = 1'b1; i_addr = 32'h20;
    sb_req = 1'b1; sb_addr = 32'h30; sb_data = 32'h5; sb_be = 4'hF;
    prev_g = 2'd3;
    for (int k = 0; k < 8 * (LAT + 1) && wins.size() < 6; k++) begin
      @(negedge clk);
      if (grant != 2'd3 && prev_g == 2'd3) wins.push_back(grant);
      prev_g = grant;
    end
    clear_inputs();
    tests_run++;
    if (wins.size() != 6) begin
      tests_failed++;
      $display("FAIL rr_count: got %0d arbitrations expected 6", wins.size());
    end
    for (int i = 0; i < wins.size(); i++) begin
      tests_run++;
      if (wins[i] !== 2'(i % 3)) begin
        tests_failed++;
        $display("FAIL rr_win%0d: got %0d expected %0d", i, wins[i], i % 3);
      end
    end
  endtask
`endif

  // Randomized traffic against a transaction-level model: the model only
  // knows when the port is free, who wins by the arbitration rules, and
  // what the single access must look like.
  task automatic test_random(input int ncyc);
    int  e, next_accept, acc_start, acc_edge, starve, rr, win;
    bit  m_active;
    bit  infl[3];
    logic [1:0]  m_owner;
    logic        m_we;
    logic [31:0] m_addr, m_wdata, rd;
    logic [3:0]  m_be;
    logic [136:0] got, exp;
    logic [2:0]  exp_bg;
    int  errs_before;

    do_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    m_active = 1'b0;
    starve = 0;
    rr = 0;
    infl[0] = 1'b0; infl[1] = 1'b0; infl[2] = 1'b0;
    m_owner = 2'd3; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_be = '0;
    acc_start = 0; acc_edge = 0;
    next_accept = edge_cnt + 1;
    errs_before = tests_failed;

    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      e = edge_cnt;

      // ---- check the window after edge e ----
      got = {mem_read_en, mem_write_en, mem_addr, mem_wdata, mem_byte_en,
             d_ready, i_ready, sb_ready, d_rdata, i_rdata};
      exp = '0;
      exp_bg = 3'b011;
      if (m_active && e >= acc_start && e <= acc_edge) exp_bg = {1'b1, m_owner};
      if (m_active && e == acc_edge) begin
        rd = ref_mem[m_addr[9:2]];
        exp = {~m_we, m_we, m_addr, m_wdata, m_be,
               m_owner == 2'd0, m_owner == 2'd1, m_owner == 2'd2,
               (m_owner == 2'd0 && !m_we) ? rd : 32'd0,
               (m_owner == 2'd1) ? rd : 32'd0};
      end
      if (tests_failed - errs_before < 10) begin
        tests_run++;
        if ({busy, grant} !== exp_bg) begin
          tests_failed++;
          $display("FAIL rand_grant_e%0d: got busy=%b grant=%0d expected busy=%b grant=%0d",
                   e, busy, grant, exp_bg[2], exp_bg[1:0]);
        end
        tests_run++;
        if (got !== exp) begin
          tests_failed++;
          $display("FAIL rand_port_e%0d: got %h expected %h", e, got, exp);
        end
      end
      if (m_active && e == acc_edge) begin
        if (m_we)
          for (int b = 0; b < 4; b++)
            if (m_be[b]) ref_mem[m_addr[9:2]][8*b +: 8] = m_wdata[8*b +: 8];
        case (m_owner)
          2'd0: d_req = 1'b0;
          2'd1: i_req = 1'b0;
          default: sb_req = 1'b0;
        endcase
        infl[m_owner] = 1'b0;
        m_active = 1'b0;
      end

      // ---- requesters ----
      if (m_active && $urandom_range(0, 1) == 0) begin
        // Fields of an accepted request may change; the latched ones count.
        case (m_owner)
          2'd0: begin d_we = 1'($urandom_range(0, 1)); d_addr = rand_addr(); d_wdata = $urandom; d_be = 4'($urandom_range(0, 15)); end
          2'd1: i_addr = rand_addr();
          default: begin sb_addr = rand_addr(); sb_data = $urandom; sb_be = 4'($urandom_range(0, 15)); end
        endcase
        if ($urandom_range(0, 7) == 0) begin
          case (m_owner)
            2'd0: d_req = 1'b0;
            2'd1: i_req = 1'b0;
            default: sb_req = 1'b0;
          endcase
        end
      end
      if (!d_req && !infl[0] && $urandom_range(0, 1) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = rand_addr();
        d_wdata = $urandom; d_be = 4'($urandom_range(0, 15)); infl[0] = 1'b1;
      end
      if (!i_req && !infl[1] && $urandom_range(0, 2) == 0) begin
        i_req = 1'b1; i_addr = rand_addr(); infl[1] = 1'b1;
      end
      if (!sb_req && !infl[2] && $urandom_range(0, 1) == 0) begin
        sb_req = 1'b1; sb_addr = rand_addr(); sb_data = $urandom;
        sb_be = 4'($urandom_range(0, 15)); infl[2] = 1'b1;
      end

      // ---- model: arbitration at edge e+1 if the port is free ----
      if (!m_active && e + 1 >= next_accept) begin
        win = 3;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        for (int off = 0; off < 3; off++) begin
          int idx;
          idx = (rr + off) % 3;
          if (win == 3 && ((idx == 0 && d_req) || (idx == 1 && i_req) || (idx == 2 && sb_req))) win = idx;
        end
        if (win != 3) rr = (win + 1) % 3;
`else
        if (sb_req && starve >= LIMIT) win = 2;
        else if (d_req)                win = 0;
        else if (i_req)                win = 1;
        else if (sb_req)               win = 2;
        if (!sb_req || win == 2) starve = 0;
        else if (starve < 15)    starve = starve + 1;
`endif
        if (win != 3) begin
          m_active  = 1'b1;
          m_owner   = 2'(win);
          acc_start = e + 1;
          acc_edge  = e + LAT;
          next_accept = e + LAT + 2;
          case (win)
            0: begin
              m_we = d_we; m_addr = d_addr;
              m_wdata = d_we ? d_wdata : 32'd0; m_be = d_we ? d_be : 4'd0;
            end
            1: begin m_we = 1'b0; m_addr = i_addr; m_wdata = 32'd0; m_be = 4'd0; end
            default: begin m_we = 1'b1; m_addr = sb_addr; m_wdata = sb_data; m_be = sb_be; end
          endcase
        end
      end
    end

    // Let any outstanding access land, then compare memory images.
    clear_inputs();
    repeat (LAT + 2) @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      tests_run++;
      if (mem[i] !== ref_mem[i]) begin
        tests_failed++;
        if (tests_failed - errs_before < 20)
          $display("FAIL rand_mem[%0d]: got %h expected %h", i, mem[i], ref_mem[i]);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    test_reset();
    test_single_read();
    test_dual_read();
    test_latency_one();
    test_reset_mid_write();
`ifndef MEM_ARB_ROUND_ROBIN_EN
    test_starvation();
`else
    test_round_robin();
`endif
    test_random(3000);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
